// File: rtl/hstl_bus_pkg.sv
// Shared types and constants for the HSTL bus turnaround controller.
package hstl_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    TURN
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, last-grant
// register advanced only when the granted request is actually accepted.
module rr_arb2
  import hstl_bus_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_accept,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic r_last;

  always_comb begin
    o_gnt_a = i_req_a && (!i_req_b || (r_last == ID_B));
    o_gnt_b = i_req_b && (!i_req_a || (r_last == ID_A));
  end

  // Last grant starts at B so that A wins the first contested round.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= ID_B;
    end else if (i_accept) begin
      r_last <= o_gnt_b ? ID_B : ID_A;
    end
  end

endmodule

// File: rtl/hstl_bus_turn_ctrl.sv
// Shares a bidirectional HSTL bus between two requesters: drives write
// data, strobes and samples reads, and inserts a turnaround gap after each.
module hstl_bus_turn_ctrl
  import hstl_bus_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int RD_LAT   = 2,
  parameter int TURN_CYC = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A_VALID,
  input  logic             B_VALID,
  input  logic             A_WR,
  input  logic             B_WR,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic [WIDTH-1:0] B_DATA,
  output logic             A_READY,
  output logic             B_READY,
  output logic             RSP_VALID,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic [WIDTH-1:0] BUS_T,
  output logic [WIDTH-1:0] BUS_I,
  input  logic [WIDTH-1:0] BUS_O,
  output logic             BUS_RD
);

  localparam int CNT_W = $clog2(max2(RD_LAT, TURN_CYC)) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_owner;
  logic [WIDTH-1:0]   r_bus_t;
  logic [WIDTH-1:0]   r_bus_i;
  logic               r_bus_rd;
  logic               r_rsp_valid;
  logic               r_rsp_id;
  logic [WIDTH-1:0]   r_rsp_data;

  logic               w_gnt_a;
  logic               w_gnt_b;
  logic               w_idle;
  logic               w_accept;
  logic               w_acc_id;
  logic               w_acc_wr;
  logic [WIDTH-1:0]   w_acc_data;

  rr_arb2 u_arb (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_req_a  (A_VALID),
    .i_req_b  (B_VALID),
    .i_accept (w_accept),
    .o_gnt_a  (w_gnt_a),
    .o_gnt_b  (w_gnt_b)
  );

  // Grants already imply VALID, so READY alone marks the accept.
  assign w_idle     = (r_state == IDLE) && !RST;
  assign A_READY    = w_idle && w_gnt_a;
  assign B_READY    = w_idle && w_gnt_b;
  assign w_accept   = A_READY || B_READY;
  assign w_acc_id   = B_READY ? ID_B : ID_A;
  assign w_acc_wr   = B_READY ? B_WR : A_WR;
  assign w_acc_data = B_READY ? B_DATA : A_DATA;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_owner     <= ID_A;
      r_bus_t     <= '1;
      r_bus_i     <= '0;
      r_bus_rd    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= ID_A;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner <= w_acc_id;
            if (w_acc_wr) begin
              r_state <= DRIVE;
              r_bus_t <= '0;
              r_bus_i <= w_acc_data;
            end else begin
              r_state  <= SAMPLE;
              r_bus_rd <= 1'b1;
              r_cnt    <= RD_LOAD;
            end
          end
        end
        DRIVE: begin
          r_state <= TURN;
          r_bus_t <= '1;
          r_cnt   <= TURN_LOAD;
        end
        SAMPLE: begin
          // Bus stays high-Z throughout SAMPLE; only BUS_RD toggles here.
          if (r_cnt == '0) begin
            r_state     <= TURN;
            r_bus_rd    <= 1'b0;
            r_rsp_data  <= BUS_O;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_owner;
            r_cnt       <= TURN_LOAD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        TURN: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BUS_T     = r_bus_t;
  assign BUS_I     = r_bus_i;
  assign BUS_RD    = r_bus_rd;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_ID    = r_rsp_id;
  assign RSP_DATA  = r_rsp_data;

endmodule

// File: tb/tb_hstl_bus_turn_ctrl.sv
// Self-checking bench: vector table plus scoreboard on bus drives and read
// responses, hand sequences for latency, arbitration, reset and turnaround.
module tb_hstl_bus_turn_ctrl;

  localparam int TURN_CYC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0, a_wr = 1'b0, b_wr = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00, bus_o = 8'h00;
  logic       a_ready, b_ready, rsp_valid, rsp_id, bus_rd;
  logic [7:0] rsp_data, bus_t, bus_i;

  logic       d1_a_valid = 1'b0, d1_a_wr = 1'b0;
  logic [7:0] d1_bus_o = 8'h00;
  logic       d1_zero = 1'b0;
  logic [7:0] d1_zero8 = 8'h00;
  logic       d1_a_ready, d1_b_ready, d1_rsp_valid, d1_rsp_id, d1_bus_rd;
  logic [7:0] d1_rsp_data, d1_bus_t, d1_bus_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       id;
    logic [7:0] data;
  } rd_exp_t;

  typedef struct {
    logic       is_b;
    logic       wr;
    logic [7:0] data;
    logic [7:0] bus_o;
    int         exp_t0;
    int         exp_rd;
    int         exp_rsp;
  } vec_t;

  logic [7:0] wr_q[$];
  rd_exp_t    rd_q[$];
  rd_exp_t    mon_e;
  vec_t       vecs[8];

  hstl_bus_turn_ctrl #(.WIDTH(8), .RD_LAT(2), .TURN_CYC(TURN_CYC)) dut (
    .CLK(clk), .RST(rst),
    .A_VALID(a_valid), .B_VALID(b_valid), .A_WR(a_wr), .B_WR(b_wr),
    .A_DATA(a_data), .B_DATA(b_data), .A_READY(a_ready), .B_READY(b_ready),
    .RSP_VALID(rsp_valid), .RSP_ID(rsp_id), .RSP_DATA(rsp_data),
    .BUS_T(bus_t), .BUS_I(bus_i), .BUS_O(bus_o), .BUS_RD(bus_rd)
  );

  hstl_bus_turn_ctrl #(.WIDTH(8), .RD_LAT(1), .TURN_CYC(1)) dut1 (
    .CLK(clk), .RST(rst),
    .A_VALID(d1_a_valid), .B_VALID(d1_zero), .A_WR(d1_a_wr), .B_WR(d1_zero),
    .A_DATA(d1_zero8), .B_DATA(d1_zero8), .A_READY(d1_a_ready), .B_READY(d1_b_ready),
    .RSP_VALID(d1_rsp_valid), .RSP_ID(d1_rsp_id), .RSP_DATA(d1_rsp_data),
    .BUS_T(d1_bus_t), .BUS_I(d1_bus_i), .BUS_O(d1_bus_o), .BUS_RD(d1_bus_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Returns at the negedge before the accepting edge.
  task automatic wait_accept(output logic won_b);
    won_b = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((a_valid && a_ready) || (b_valid && b_ready)) begin
        won_b = b_valid && b_ready;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: no READY within 40 cycles at %0t", $time);
  endtask

  // Scoreboard: push on accept, pop on bus drive / read response.
  always @(negedge clk) begin
    if (!rst) begin
      check("no_contention", 32'(bus_rd && (bus_t != 8'hFF)), 32'd0);
      check("no_contention_d1", 32'(d1_bus_rd && (d1_bus_t != 8'hFF)), 32'd0);
      check("bus_t_uniform", 32'((bus_t == 8'h00) || (bus_t == 8'hFF)), 32'd1);
      if (a_valid && a_ready) begin
        if (a_wr) wr_q.push_back(a_data);
        else rd_q.push_back('{id: 1'b0, data: bus_o});
        $display("txn t=%0t A %s data=%02h", $time, a_wr ? "wr" : "rd", a_wr ? a_data : bus_o);
      end
      if (b_valid && b_ready) begin
        if (b_wr) wr_q.push_back(b_data);
        else rd_q.push_back('{id: 1'b1, data: bus_o});
        $display("txn t=%0t B %s data=%02h", $time, b_wr ? "wr" : "rd", b_wr ? b_data : bus_o);
      end
      if (bus_t == 8'h00) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_drive: bus_i=%02h with no queued write at %0t", bus_i, $time);
        end else begin
          check("wr_data", 32'(bus_i), 32'(wr_q.pop_front()));
        end
      end
      if (rsp_valid) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_data=%02h with no queued read at %0t", rsp_data, $time);
        end else begin
          mon_e = rd_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    logic       won_b;
    logic       drop;
    logic [7:0] last_wr;
    int         t0_cnt, rd_cnt, rsp_first, rd_last, t0_first;

    vecs[0] = '{1'b0, 1'b1, 8'hA5, 8'h00, 1, 0, -1};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 8'h3C, 0, 2, 2};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 8'hC3, 0, 2, 2};
    vecs[3] = '{1'b1, 1'b1, 8'h5A, 8'h00, 1, 0, -1};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 1, 0, -1};
    vecs[5] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1, 0, -1};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 0, 2, 2};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 8'hFF, 0, 2, 2};
    last_wr = 8'h00;

    // Reset: READY must stay low with requests pending.
    a_valid = 1'b1; b_valid = 1'b1; a_wr = 1'b1; b_wr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_a_ready", 32'(a_ready), 32'd0);
      check("rst_b_ready", 32'(b_ready), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("rst_bus_t", 32'(bus_t), 32'hFF);
    check("rst_bus_i", 32'(bus_i), 32'h00);
    check("rst_bus_rd", 32'(bus_rd), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'h00);

    // Table of single-requester transactions with per-cycle window counts.
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      bus_o   = vecs[v].bus_o;
      a_valid = !vecs[v].is_b;
      b_valid = vecs[v].is_b;
      a_wr    = vecs[v].wr;
      b_wr    = vecs[v].wr;
      a_data  = vecs[v].data;
      b_data  = vecs[v].data;
      wait_accept(won_b);
      check("vec_winner", 32'(won_b), 32'(vecs[v].is_b));
      t0_cnt = 0; rd_cnt = 0; rsp_first = -1;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (i == 0) begin a_valid = 1'b0; b_valid = 1'b0; end
        @(negedge clk);
        if (bus_t == 8'h00) t0_cnt++;
        if (bus_rd) rd_cnt++;
        if (rsp_valid && rsp_first < 0) rsp_first = i;
      end
      if (vecs[v].wr) last_wr = vecs[v].data;
      check("vec_drive_cycles", 32'(t0_cnt), 32'(vecs[v].exp_t0));
      check("vec_rd_cycles", 32'(rd_cnt), 32'(vecs[v].exp_rd));
      check("vec_rsp_cycle", 32'(rsp_first), 32'(vecs[v].exp_rsp));
      check("vec_bus_i_hold", 32'(bus_i), 32'(last_wr));
    end

    // Write-to-READY latency with A kept valid.
    @(posedge clk); #1;
    a_valid = 1'b1; a_wr = 1'b1; a_data = 8'h5A;
    wait_accept(won_b);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) a_data = 8'h77;
      @(negedge clk);
      check("wr_ready_lat", 32'(a_ready), 32'(i == 3));
      check("wr_bus_t", 32'(bus_t), (i == 0) ? 32'h00 : 32'hFF);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (6) @(negedge clk);

    // B read aborted by reset during SAMPLE; then A must win the first tie.
    @(posedge clk); #1;
    bus_o = 8'hBD; b_valid = 1'b1; b_wr = 1'b0;
    wait_accept(won_b);
    @(posedge clk); #1;
    b_valid = 1'b0; rst = 1'b1;
    rd_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_bus_t", 32'(bus_t), 32'hFF);
    check("abort_bus_rd", 32'(bus_rd), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    a_valid = 1'b1; b_valid = 1'b1; a_wr = 1'b1; b_wr = 1'b1;
    a_data = 8'h11; b_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      wait_accept(won_b);
      check("rr_grant", 32'(won_b), 32'(k % 2));
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Read immediately followed by a write from the same requester.
    @(posedge clk); #1;
    bus_o = 8'h99; a_valid = 1'b1; a_wr = 1'b0; a_data = 8'h42;
    wait_accept(won_b);
    rd_last = -1; t0_first = -1; drop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0) a_wr = 1'b1;
      if (drop) a_valid = 1'b0;
      @(negedge clk);
      if (bus_rd) rd_last = i;
      if (bus_t == 8'h00 && t0_first < 0) t0_first = i;
      if (a_valid && a_ready) drop = 1'b1;
    end
    check("rd_last_cycle", 32'(rd_last), 32'd1);
    check("rd_to_wr_gap", 32'(t0_first - (rd_last + 1)), 32'(TURN_CYC + 1));

    // Minimum latencies: RD_LAT=1, TURN_CYC=1 instance.
    @(posedge clk); #1;
    d1_bus_o = 8'h00; d1_a_valid = 1'b1; d1_a_wr = 1'b0;
    drop = 1'b0;
    for (int n = 0; n < 20 && !drop; n++) begin
      @(negedge clk);
      if (d1_a_ready) drop = 1'b1;
    end
    check("d1_accept_seen", 32'(drop), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) d1_bus_o = 8'h6E;
      if (i == 1) d1_bus_o = 8'hEE;
      @(negedge clk);
      check("d1_bus_rd", 32'(d1_bus_rd), 32'(i == 0));
      check("d1_rsp_valid", 32'(d1_rsp_valid), 32'(i == 1));
      check("d1_ready", 32'(d1_a_ready), 32'(i == 2));
      if (i == 1) begin
        check("d1_rsp_data", 32'(d1_rsp_data), 32'h6E);
        check("d1_rsp_id", 32'(d1_rsp_id), 32'd0);
      end
    end
    @(posedge clk); #1;
    d1_a_valid = 1'b0;
    repeat (6) @(negedge clk);

    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hstl_bus_turn_ctrl.md
# hstl_bus_turn_ctrl

Sequencing controller for a shared bidirectional HSTL class II DCI data bus built from per-bit tristate IO buffers. The block shares the bus between two requesters (A, B) with round-robin arbitration and drives the buffer tristate and data inputs for write cycles. For read cycles it releases the bus, strobes the external device, samples the buffer outputs and inserts a fixed turnaround gap after every transfer. It sits between the core-side request logic and the IO buffer instances at the pad ring.

## Interface
- WIDTH, 8, bus data width (number of IO buffer bits)
- RD_LAT, 2, cycles the bus stays released before the read sample is taken (≥1)
- TURN_CYC, 2, turnaround cycles with bus released after each transfer (≥1)
- CLK  input  1  sole clock, all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- A_VALID, B_VALID  input  1  request pending
- A_WR, B_WR  input  1  1 = write, 0 = read
- A_DATA, B_DATA  input  WIDTH  write data
- A_READY, B_READY  output  1  request accepted on this edge when VALID=1
- RSP_VALID  output  1  one-cycle read response strobe
- RSP_ID  output  1  0 = A, 1 = B, owner of response
- RSP_DATA  output  WIDTH  read data
- BUS_T  output  WIDTH  to buffer tristate controls, 1 = high-Z (all bits equal)
- BUS_I  output  WIDTH  to buffer data inputs
- BUS_O  input  WIDTH  from buffer data outputs
- BUS_RD  output  1  tells external device to drive bus

## Operation
- States: IDLE, DRIVE, SAMPLE, TURN.
- IDLE: READY asserted combinationally to arbitration winner only; loser READY=0. Accept = VALID&READY at edge. Write → DRIVE; read → SAMPLE; none → stay.
- Arbitration: single valid wins; both valid → requester not granted last; after reset A has priority.
- Requesters hold VALID, WR, DATA stable until accepted.
- DRIVE (1 cycle): BUS_T all 0, BUS_I = accepted data. → TURN.
- SAMPLE (RD_LAT cycles, down-counter): BUS_T all 1, BUS_RD=1. On last SAMPLE edge BUS_O registered into RSP_DATA. → TURN.
- TURN (TURN_CYC cycles): BUS_T all 1, BUS_RD=0. RSP_VALID=1 in first TURN cycle only if preceding state was SAMPLE, with RSP_ID = owner. → IDLE.
- BUS_I holds last driven value outside DRIVE; only BUS_T qualifies it.
- BUS_T is never 0 while BUS_RD=1 (no contention); enforced by state encoding, asserted in bench.
- Counter width $clog2(max(RD_LAT,TURN_CYC))+1; loads N-1 on entry, exits at 0.

## Timing
- Reset values (cycle after RST sampled high): state IDLE, BUS_T all 1, BUS_I 0, BUS_RD 0, RSP_VALID 0, RSP_ID 0, RSP_DATA 0, counter 0, priority A. READY=0 while RST high.
- Reset mid-transfer: aborts at next edge, no RSP_VALID for aborted read, bus released.
- Write accepted at edge N: BUS_T=0 during cycle N..N+1; released from N+1 for TURN_CYC cycles; READY earliest in cycle starting at N+1+TURN_CYC.
- Read accepted at edge N: BUS_RD=1 for cycles N..N+RD_LAT; BUS_O sampled at edge N+RD_LAT; RSP_VALID high cycle N+RD_LAT..N+RD_LAT+1.
- Throughput: one write per 2+TURN_CYC cycles, one read per 1+RD_LAT+TURN_CYC cycles.
- Arbitration pointer updates only on accept edge.

## Structure
- Package hstl_bus_pkg: state enum (IDLE, DRIVE, SAMPLE, TURN), requester-id constants ID_A=0, ID_B=1.
- Sub-module rr_arb2: two-request round-robin arbiter, grant combinational, last-grant register updated on accept strobe.
- Top holds FSM, counter, data/response registers.

## Test plan
- Reset then A write 8'hA5 (defaults): BUS_T=0, BUS_I=8'hA5 for exactly 1 cycle, then 2 cycles high-Z, A_READY next high 3 cycles after accept.
- B read, BUS_O driven 8'h3C: BUS_RD high 2 cycles, RSP_VALID 1 cycle with RSP_DATA=8'h3C, RSP_ID=1.
- A and B valid continuously (writes 8'h11/8'h22): grants alternate A,B,A,B; BUS_I sequence 11,22,11,22.
- Assert RST during SAMPLE of read: next cycle BUS_T all 1, BUS_RD 0, no RSP_VALID; next grant goes to A.
- Read followed immediately by write: no cycle with BUS_T=0 and BUS_RD=1; write drive starts ≥TURN_CYC+1 cycles after BUS_RD falls.
- RD_LAT=1, TURN_CYC=1: read completes in 3 cycles, response data matches BUS_O at sample edge.
